clk_div_ctrl: RTL

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with a valid/ready divisor port.
// A new divisor takes effect only at a period boundary, so the output never shows a short or stretched phase.
module clk_div_ctrl #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic [W-1:0] div_n,
  output logic         clk_div,
  output logic         tick,
  output logic         busy,
  output logic [31:0]  period_cnt,
  output logic [1:0]   state_dbg
);

  // cfg handshake: a divisor transfers on a rising edge where cfg_valid && cfg_ready.
  // cfg_ready is high in IDLE and RUN only; a producer must hold cfg_div stable while cfg_valid is high.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t       state_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] div_q;
  logic [W-1:0] pend_q;
  logic         pend_vld_q;
  logic         clk_div_q;
  logic         cfg_err_q;
  logic [31:0]  period_q;

  logic         accept;
  logic         cfg_legal;
  logic         boundary;
  logic [W-1:0] half_m1;

  always_comb begin
    accept    = cfg_valid && cfg_ready;
    cfg_legal = (cfg_div >= W'(2));
    boundary  = (state_q != IDLE) && (cnt_q == div_q - W'(1));
    half_m1   = (div_q >> 1) - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= W'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_div_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      period_q   <= '0;
    end else begin
      cfg_err_q <= accept && !cfg_legal;

      // Counter and waveform run identically in RUN, PEND and STOP.
      if (state_q != IDLE) begin
        if (boundary) begin
          cnt_q     <= '0;
          clk_div_q <= 1'b0;
          period_q  <= period_q + 32'd1;
        end else begin
          cnt_q <= cnt_q + W'(1);
          if (cnt_q == half_m1) clk_div_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (accept && cfg_legal) div_q <= cfg_div;
          if (en) state_q <= RUN;
        end
        RUN: begin
          if (accept && cfg_legal) begin
            pend_q     <= cfg_div;
            pend_vld_q <= 1'b1;
          end
          if (!en)                       state_q <= STOP;
          else if (accept && cfg_legal)  state_q <= PEND;
        end
        PEND: begin
          if (boundary) begin
            div_q      <= pend_q;
            pend_vld_q <= 1'b0;
            state_q    <= en ? RUN : STOP;
          end else if (!en) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          if (boundary) begin
            if (pend_vld_q) div_q <= pend_q;
            pend_vld_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready  = (state_q == IDLE) || (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign tick       = boundary;
  assign cfg_err    = cfg_err_q;
  assign div_n      = div_q;
  assign clk_div    = clk_div_q;
  assign period_cnt = period_q;
  assign state_dbg  = state_q;

endmodule
